fridge_readback: RTL and testbench
==================================

Name: fridge_readback

Overview:
- Readback/transmit side of the fridge settings store. The settings writer loads values; this block reads them back.
- Takes the stored settings (fridge/freezer temperature, fridge/freezer capacity, ice maker) and sends the selected one, or all five in scan mode, as a framed serial word on a single line for the display/service controller.
- Uses the same power input and the same s0/s1/s2 selector meaning as the settings writer.

Parameters:
- BIT_CYCLES, 4, clock cycles each serial bit is held on tx (must be >= 1).
- DATA_W, 5, width of each stored setting field.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- i  input  1  power; low aborts any frame and holds the block idle
- s0, s1  input  1 each  item select: {s1,s0}=00 temperature, 01 capacity, 10 ice, 11 invalid
- s2  input  1  0 fridge, 1 freezer (ignored for ice)
- req  input  1  single-item request, sampled only in IDLE
- scan  input  1  all-item request, sampled only in IDLE; takes priority over req
- fgt, frt, fgc, frc  input  DATA_W each  stored settings
- ice  input  1  ice maker state (sent as data = {4'b0, ice})
- tx  output  1  serial line, idles high
- busy  output  1  high while a frame or scan sequence is in progress
- done  output  1  one-cycle pulse at completion
- err  output  1  one-cycle pulse on an invalid request

Behaviour:
- Reset values: tx=1, busy=0, done=0, err=0, state=IDLE, all counters 0.
- Tag encoding (3 bits): 0 fgt, 1 frt, 2 fgc, 3 frc, 4 ice.
- Frame is 11 bits, each bit held BIT_CYCLES cycles:
  - start bit 0
  - tag[0..2], LSB first
  - data[0..4], LSB first
  - even parity over tag and data (8 bits)
  - stop bit 1
- Total frame time is 11*BIT_CYCLES cycles.
- Capture: in IDLE, with i=1 and req (or scan) high at edge k:
  - the selected field is latched into the shift register at edge k;
  - busy=1 and tx=0 (start bit) from edge k+1.
- Later changes to the settings inputs or selectors do not affect a frame in flight.
- States and transitions:
  - IDLE: go to START on a valid request.
  - START -> TAG -> DATA -> PARITY -> STOP: advance each time cyc_cnt reaches BIT_CYCLES-1. A bit counter indexes TAG (0..2) and DATA (0..4).
  - STOP, single request: go to IDLE.
  - STOP, scan with tag<4: go to LOAD.
  - LOAD: one cycle; tx=1, next tag's data captured, then START.
- Scan: sends tags 0,1,2,3,4 in order with exactly one idle-high LOAD cycle between frames. Each item's data is captured at its own LOAD, so a scan takes 5*11*BIT_CYCLES + 4 cycles.
- Completion: at the cycle after the last STOP cycle, done=1 for one cycle, busy=0, tx=1. For a scan, done pulses once, after tag 4 only.
- Invalid request: {s1,s0}=11 with req=1, scan=0, in IDLE with i=1 causes err=1 for the next cycle; no frame, busy stays 0.
- Requests while busy are ignored; no queuing. req and scan both high selects scan.
- Power: while i=0, requests are ignored. If i falls mid-frame, at the next edge: state=IDLE, tx=1, busy=0, no done. Restoring i does not resume the frame.
- rst asserted mid-frame: all outputs return to their reset values at that edge.
- BIT_CYCLES=1: every bit lasts one cycle; no off-by-one at bit boundaries.

Decomposition:
- Shared package fridge_pkg holds:
  - tag constants (TAG_FGT..TAG_ICE)
  - selector codes (SEL_TEMP, SEL_CAP, SEL_ICE)
  - FRAME_BITS = 11
  - the state enum
- One sub-module, fridge_item_mux: combinational; maps {s1,s0,s2} or a scan tag to (tag, data, valid). Shared by the single-request and scan paths.

Test Plan:
- BIT_CYCLES=4, fgt=5'b10110, s1s0=00, s2=0, req pulse:
  - tx after 1 cycle: 0, then tag 0,0,0, data 0,1,1,0,1, parity 1, stop 1, each 4 cycles;
  - busy=1 for 44 cycles;
  - done pulses at cycle 45.
- ice=1, s1s0=10, req: tag 4 (bits 0,0,1), data 1,0,0,0,0, parity 0.
- scan=1 with fgt=3, frt=7, fgc=8, frc=24, ice=0:
  - five frames with tags 0..4 and matching data;
  - one idle-high cycle between frames;
  - busy=1 for 5*44+4=224 cycles;
  - a single done pulse.
- s1s0=11, req: err pulses one cycle; tx stays 1; busy stays 0.
- Mid-frame events:
  - drop i at cycle 20 of a frame: next edge tx=1, busy=0, no done; a req while i=0 is ignored;
  - assert rst at cycle 10: all outputs at reset values.
- req during busy is ignored. Change fgt mid-frame: transmitted data stays the captured value. Also repeat the single-request test with BIT_CYCLES=1 (11-cycle frame).

Source files
------------

// File: rtl/fridge_pkg.sv
// ============================================================================
// fridge_pkg : shared tags, selector codes, frame size and FSM states
// Revision   : 1.0
// ============================================================================
`default_nettype none

package fridge_pkg;

    localparam logic [2:0] TAG_FGT = 3'd0;
    localparam logic [2:0] TAG_FRT = 3'd1;
    localparam logic [2:0] TAG_FGC = 3'd2;
    localparam logic [2:0] TAG_FRC = 3'd3;
    localparam logic [2:0] TAG_ICE = 3'd4;

    localparam logic [1:0] SEL_TEMP = 2'b00;
    localparam logic [1:0] SEL_CAP  = 2'b01;
    localparam logic [1:0] SEL_ICE  = 2'b10;

    localparam int FRAME_BITS = 11;
    localparam int TAG_BITS   = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_TAG    = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5,
        ST_LOAD   = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/fridge_item_mux.sv
// ============================================================================
// fridge_item_mux : maps selectors or a scan tag to (tag, data, valid)
// Revision        : 1.0
// ============================================================================
`default_nettype none

module fridge_item_mux #(
    parameter int DATA_W = 5
) (
    input  logic              scan_mode,
    input  logic [2:0]        scan_tag,
    input  logic              s0,
    input  logic              s1,
    input  logic              s2,
    input  logic [DATA_W-1:0] fgt,
    input  logic [DATA_W-1:0] frt,
    input  logic [DATA_W-1:0] fgc,
    input  logic [DATA_W-1:0] frc,
    input  logic              ice,
    output logic [2:0]        tag,
    output logic [DATA_W-1:0] data,
    output logic              valid
);
    import fridge_pkg::*;

    always_comb begin
        tag   = TAG_FGT;
        valid = 1'b1;
        if (scan_mode) begin
            tag   = scan_tag;
            valid = (scan_tag <= TAG_ICE);
        end else begin
            case ({s1, s0})
                SEL_TEMP: tag = s2 ? TAG_FRT : TAG_FGT;
                SEL_CAP:  tag = s2 ? TAG_FRC : TAG_FGC;
                SEL_ICE:  tag = TAG_ICE;
                default:  valid = 1'b0;
            endcase
        end
    end

    always_comb begin
        data = '0;
        case (tag)
            TAG_FGT: data = fgt;
            TAG_FRT: data = frt;
            TAG_FGC: data = fgc;
            TAG_FRC: data = frc;
            TAG_ICE: data = {{(DATA_W-1){1'b0}}, ice};
            default: data = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/fridge_readback.sv
// ============================================================================
// fridge_readback : serialises stored fridge settings as framed words on tx
// Revision        : 1.0
// ============================================================================
`default_nettype none

module fridge_readback #(
    parameter int BIT_CYCLES = 4,
    parameter int DATA_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i,
    input  logic              s0,
    input  logic              s1,
    input  logic              s2,
    input  logic              req,
    input  logic              scan,
    input  logic [DATA_W-1:0] fgt,
    input  logic [DATA_W-1:0] frt,
    input  logic [DATA_W-1:0] fgc,
    input  logic [DATA_W-1:0] frc,
    input  logic              ice,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic              err
);
    import fridge_pkg::*;

    localparam int CW        = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int DATA_BITS = FRAME_BITS - TAG_BITS - 3;
    localparam int BW        = ($clog2(DATA_BITS) > 2) ? $clog2(DATA_BITS) : 2;

    state_t            state;
    state_t            next_state;
    logic [CW-1:0]     cyc_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [2:0]        shift_tag;
    logic [DATA_W-1:0] shift_data;
    logic              scan_mode;

    logic              mux_scan;
    logic [2:0]        mux_scan_tag;
    logic [2:0]        mux_tag;
    logic [DATA_W-1:0] mux_data;
    logic              mux_valid;

    logic              bit_end;
    logic              load_en;
    logic              done_set;
    logic              err_set;

    // In IDLE the selectors (or scan tag 0) choose the item; in LOAD the next scan tag does.
    assign mux_scan     = (state == ST_IDLE) ? scan : 1'b1;
    assign mux_scan_tag = (state == ST_IDLE) ? TAG_FGT : shift_tag + 3'd1;
    assign bit_end      = (cyc_cnt == CW'(BIT_CYCLES - 1));

    fridge_item_mux #(
        .DATA_W (DATA_W)
    ) u_item_mux (
        .scan_mode (mux_scan),
        .scan_tag  (mux_scan_tag),
        .s0        (s0),
        .s1        (s1),
        .s2        (s2),
        .fgt       (fgt),
        .frt       (frt),
        .fgc       (fgc),
        .frc       (frc),
        .ice       (ice),
        .tag       (mux_tag),
        .data      (mux_data),
        .valid     (mux_valid)
    );

    always_comb begin
        next_state = state;
        load_en    = 1'b0;
        done_set   = 1'b0;
        err_set    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (scan || (req && mux_valid)) begin
                    next_state = ST_START;
                    load_en    = 1'b1;
                end else if (req) begin
                    err_set = 1'b1;
                end
            end
            ST_START:  if (bit_end) next_state = ST_TAG;
            ST_TAG:    if (bit_end && bit_cnt == BW'(TAG_BITS - 1)) next_state = ST_DATA;
            ST_DATA:   if (bit_end && bit_cnt == BW'(DATA_BITS - 1)) next_state = ST_PARITY;
            ST_PARITY: if (bit_end) next_state = ST_STOP;
            ST_STOP: begin
                if (bit_end) begin
                    if (scan_mode && shift_tag < TAG_ICE) begin
                        next_state = ST_LOAD;
                    end else begin
                        next_state = ST_IDLE;
                        done_set   = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                next_state = ST_START;
                load_en    = 1'b1;
            end
            default: next_state = ST_IDLE;
        endcase
        // Loss of power aborts silently: no done, no err, nothing captured.
        if (!i) begin
            next_state = ST_IDLE;
            load_en    = 1'b0;
            done_set   = 1'b0;
            err_set    = 1'b0;
        end
    end

    always_comb begin
        tx   = 1'b1;
        busy = (state != ST_IDLE);
        case (state)
            ST_START:  tx = 1'b0;
            ST_TAG:    tx = shift_tag[bit_cnt[1:0]];
            ST_DATA:   tx = shift_data[bit_cnt];
            ST_PARITY: tx = ^{shift_tag, shift_data};
            default:   tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
            shift_tag  <= '0;
            shift_data <= '0;
            scan_mode  <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state <= next_state;
            done  <= done_set;
            err   <= err_set;

            if (state == ST_IDLE || state == ST_LOAD || next_state == ST_IDLE || bit_end) begin
                cyc_cnt <= '0;
            end else begin
                cyc_cnt <= cyc_cnt + CW'(1);
            end

            if ((state == ST_TAG || state == ST_DATA) && next_state == state) begin
                if (bit_end) begin
                    bit_cnt <= bit_cnt + BW'(1);
                end
            end else begin
                bit_cnt <= '0;
            end

            if (load_en) begin
                shift_tag  <= mux_tag;
                shift_data <= mux_data;
                if (state == ST_IDLE) begin
                    scan_mode <= scan;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fridge_readback.sv
// ============================================================================
// tb_fridge_readback : scoreboard bench for fridge_readback (BIT_CYCLES 4 and 1)
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_fridge_readback;

    typedef struct {
        logic tx;
        logic busy;
        logic done;
        logic err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, i, s0, s1, s2, req, scan, ice;
    logic [4:0] fgt, frt, fgc, frc;
    logic       tx4, busy4, done4, err4;
    logic       tx1, busy1, done1, err1;
    logic       use1;
    logic [3:0] obs;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    assign obs = use1 ? {tx1, busy1, done1, err1} : {tx4, busy4, done4, err4};

    fridge_readback #(.BIT_CYCLES(4), .DATA_W(5)) u_dut4 (
        .clk(clk), .rst(rst), .i(i), .s0(s0), .s1(s1), .s2(s2),
        .req(req), .scan(scan), .fgt(fgt), .frt(frt), .fgc(fgc), .frc(frc),
        .ice(ice), .tx(tx4), .busy(busy4), .done(done4), .err(err4)
    );

    fridge_readback #(.BIT_CYCLES(1), .DATA_W(5)) u_dut1 (
        .clk(clk), .rst(rst), .i(i), .s0(s0), .s1(s1), .s2(s2),
        .req(req), .scan(scan), .fgt(fgt), .frt(frt), .fgc(fgc), .frc(frc),
        .ice(ice), .tx(tx1), .busy(busy1), .done(done1), .err(err1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input logic t, input logic b, input logic d, input logic x, input int n);
        exp_t en;
        en.tx = t; en.busy = b; en.done = d; en.err = x;
        for (int k = 0; k < n; k++) q.push_back(en);
    endtask

    // Reference frame: start, tag LSB first, data LSB first, even parity, stop.
    task automatic push_frame(input logic [2:0] tg, input logic [4:0] dt, input int bc);
        logic [10:0] fr;
        fr = {1'b1, ^{tg, dt}, dt, tg, 1'b0};
        for (int b = 0; b < 11; b++) push_n(fr[b], 1'b1, 1'b0, 1'b0, bc);
    endtask

    task automatic test_reset();
        checks++;
        if ({tx4, busy4, done4, err4, tx1, busy1, done1, err1} !== 8'b1000_1000)
            $display("FAIL reset: tx/busy/done/err both duts=%b required 10001000",
                     {tx4, busy4, done4, err4, tx1, busy1, done1, err1});
        else passed++;
    endtask

    task automatic test_item(input string name, input int bc, input logic [1:0] sel,
                             input logic sv2, input logic [2:0] tg, input logic [4:0] dt);
        use1 = (bc == 1);
        {s1, s0} = sel; s2 = sv2;
        push_frame(tg, dt, bc);
        push_n(1'b1, 1'b0, 1'b1, 1'b0, 1);
        push_n(1'b1, 1'b0, 1'b0, 1'b0, 2);
        req = 1'b1;
        for (int n = 0; q.size() > 0; n++) begin
            step();
            if (n == 0) req = 1'b0;
            e = q.pop_front();
            checks++;
            if (obs !== {e.tx, e.busy, e.done, e.err})
                $display("FAIL %s cyc %0d: tx/busy/done/err=%b required %b",
                         name, n + 1, obs, {e.tx, e.busy, e.done, e.err});
            else passed++;
        end
    endtask

    task automatic test_capture_and_busy_req();
        use1 = 1'b0;
        {s1, s0} = 2'b00; s2 = 1'b1; frt = 5'b01011;
        push_frame(3'd1, 5'b01011, 4);
        push_n(1'b1, 1'b0, 1'b1, 1'b0, 1);
        push_n(1'b1, 1'b0, 1'b0, 1'b0, 4);
        req = 1'b1;
        for (int n = 0; q.size() > 0; n++) begin
            step();
            case (n)
                0:  req = 1'b0;
                8:  begin frt = 5'b10100; s2 = 1'b0; fgt = 5'b11111; end
                15: req = 1'b1;
                16: begin req = 1'b0; scan = 1'b1; end
                17: scan = 1'b0;
                default: ;
            endcase
            e = q.pop_front();
            checks++;
            if (obs !== {e.tx, e.busy, e.done, e.err})
                $display("FAIL capture cyc %0d: tx/busy/done/err=%b required %b",
                         n + 1, obs, {e.tx, e.busy, e.done, e.err});
            else passed++;
        end
    endtask

    task automatic test_scan(input int bc);
        use1 = (bc == 1);
        fgt = 5'd3; frt = 5'd7; fgc = 5'd8; frc = 5'd24; ice = 1'b0;
        {s1, s0} = 2'b11;
        push_frame(3'd0, 5'd3, bc);  push_n(1'b1, 1'b1, 1'b0, 1'b0, 1);
        push_frame(3'd1, 5'd7, bc);  push_n(1'b1, 1'b1, 1'b0, 1'b0, 1);
        push_frame(3'd2, 5'd8, bc);  push_n(1'b1, 1'b1, 1'b0, 1'b0, 1);
        push_frame(3'd3, 5'd24, bc); push_n(1'b1, 1'b1, 1'b0, 1'b0, 1);
        push_frame(3'd4, 5'd0, bc);
        push_n(1'b1, 1'b0, 1'b1, 1'b0, 1);
        push_n(1'b1, 1'b0, 1'b0, 1'b0, 3);
        scan = 1'b1; req = 1'b1;
        for (int n = 0; q.size() > 0; n++) begin
            step();
            if (n == 0) begin scan = 1'b0; req = 1'b0; end
            e = q.pop_front();
            checks++;
            if (obs !== {e.tx, e.busy, e.done, e.err})
                $display("FAIL scan bc%0d cyc %0d: tx/busy/done/err=%b required %b",
                         bc, n + 1, obs, {e.tx, e.busy, e.done, e.err});
            else passed++;
        end
    endtask

    task automatic test_invalid();
        use1 = 1'b0;
        {s1, s0} = 2'b11; s2 = 1'b0;
        push_n(1'b1, 1'b0, 1'b0, 1'b1, 1);
        push_n(1'b1, 1'b0, 1'b0, 1'b0, 4);
        req = 1'b1;
        for (int n = 0; q.size() > 0; n++) begin
            step();
            if (n == 0) req = 1'b0;
            e = q.pop_front();
            checks++;
            if (obs !== {e.tx, e.busy, e.done, e.err})
                $display("FAIL invalid cyc %0d: tx/busy/done/err=%b required %b",
                         n + 1, obs, {e.tx, e.busy, e.done, e.err});
            else passed++;
        end
    endtask

    task automatic test_power_drop();
        use1 = 1'b0;
        {s1, s0} = 2'b00; s2 = 1'b0; fgt = 5'b10110;
        push_frame(3'd0, 5'b10110, 4);
        while (q.size() > 20) void'(q.pop_back());
        push_n(1'b1, 1'b0, 1'b0, 1'b0, 12);
        req = 1'b1;
        for (int n = 0; q.size() > 0; n++) begin
            step();
            case (n)
                0:  req = 1'b0;
                19: i = 1'b0;
                21: req = 1'b1;
                23: req = 1'b0;
                26: i = 1'b1;
                default: ;
            endcase
            e = q.pop_front();
            checks++;
            if (obs !== {e.tx, e.busy, e.done, e.err})
                $display("FAIL power cyc %0d: tx/busy/done/err=%b required %b",
                         n + 1, obs, {e.tx, e.busy, e.done, e.err});
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        use1 = 1'b0;
        {s1, s0} = 2'b00; s2 = 1'b0; fgt = 5'b01101;
        push_frame(3'd0, 5'b01101, 4);
        while (q.size() > 10) void'(q.pop_back());
        push_n(1'b1, 1'b0, 1'b0, 1'b0, 6);
        req = 1'b1;
        for (int n = 0; q.size() > 0; n++) begin
            step();
            if (n == 0) req = 1'b0;
            if (n == 9) rst = 1'b1;
            if (n == 11) rst = 1'b0;
            e = q.pop_front();
            checks++;
            if (obs !== {e.tx, e.busy, e.done, e.err})
                $display("FAIL rst_mid cyc %0d: tx/busy/done/err=%b required %b",
                         n + 1, obs, {e.tx, e.busy, e.done, e.err});
            else passed++;
        end
    endtask

    initial begin
        use1 = 1'b0;
        rst = 1'b1; i = 1'b1; req = 1'b0; scan = 1'b0;
        s0 = 1'b0; s1 = 1'b0; s2 = 1'b0; ice = 1'b0;
        fgt = '0; frt = '0; fgc = '0; frc = '0;
        repeat (3) step();
        test_reset();
        rst = 1'b0;
        repeat (2) step();

        fgt = 5'b10110;
        test_item("single_fgt", 4, 2'b00, 1'b0, 3'd0, 5'b10110);
        ice = 1'b1;
        test_item("ice", 4, 2'b10, 1'b1, 3'd4, 5'b00001);
        frc = 5'b11001;
        test_item("cap_freezer", 4, 2'b01, 1'b1, 3'd3, 5'b11001);
        fgc = 5'b00110;
        test_item("cap_fridge", 4, 2'b01, 1'b0, 3'd2, 5'b00110);
        test_capture_and_busy_req();
        repeat (2) step();
        test_scan(4);
        test_invalid();
        test_power_drop();
        test_reset_mid();
        repeat (2) step();

        fgt = 5'b10110;
        test_item("single_fgt_bc1", 1, 2'b00, 1'b0, 3'd0, 5'b10110);
        repeat (50) step();
        test_scan(1);
        repeat (50) step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
